tl_fetch_arbiter: RTL and testbench
===================================

# tl_fetch_arbiter

Two-requester TileLink-UH master arbiter for the frontend. It lets the instruction cache (requester 0) and the page-table walker (requester 1) share the single external TileLink master port. It grants one requester at a time and keeps that grant until every D-channel beat of the transaction has been returned. Because the bus carries no source field, D responses are routed back purely by the recorded owner.

## Interface
- No parameters. Protocol constants come from the shared package.
- `cpu_clock_i` in 1: the single clock.
- `cpu_reset_ni` in 1: reset, asynchronous assert, active-low.
- `m0_a_opcode/param/size/address/mask/data/corrupt` in 3/3/4/32/4/32/1: icache A-channel fields.
- `m0_a_valid` in 1, `m0_a_ready` out 1: icache A handshake.
- `m0_d_opcode/param/size/denied/data/corrupt` out 3/2/4/1/32/1: icache D-channel fields.
- `m0_d_valid` out 1, `m0_d_ready` in 1: icache D handshake.
- `m1_*`: page-table-walker port, identical shape and widths to `m0_*`.
- `bus_a_opcode/param/size/address/mask/data/corrupt` out 3/3/4/32/4/32/1: shared A channel.
- `bus_a_valid` out 1, `bus_a_ready` in 1: shared A handshake.
- `bus_d_opcode/param/size/denied/data/corrupt` in 3/2/4/1/32/1: shared D channel.
- `bus_d_valid` in 1, `bus_d_ready` out 1: shared D handshake.
- `busy_o` out 1: high whenever state ≠ IDLE.

## Operation
- The FSM has three states: IDLE, REQ and DATA. Registers: `owner` (1 bit), `last_grant` (1 bit), `beats_left` (4 bits).
- **IDLE**
  - If any `mX_a_valid` is high, select a winner, write it to `owner` and to `last_grant`, then go to REQ.
  - If neither is valid, stay in IDLE.
- **REQ**
  - `bus_a_*` carries the owner's A fields.
  - `bus_a_valid` = owner `a_valid`.
  - Owner `a_ready` = `bus_a_ready`; the non-owner sees `a_ready` = 0.
  - On the A handshake, load `beats_left` = (opcode == Get && size > 2) ? (1 << (size−2)) − 1 : 0, then go to DATA.
- **DATA**
  - Owner `d_*` = `bus_d_*`.
  - Owner `d_valid` = `bus_d_valid`; `bus_d_ready` = owner `d_ready`.
  - On each D handshake: if `beats_left` == 0, go to IDLE; otherwise decrement `beats_left`.
- Outside DATA, `bus_d_ready` = 0 and both `mX_d_valid` = 0. A stray D beat is stalled, not dropped.
- `denied` and `corrupt` beats count like any other beat; the arbiter forwards them and takes no further action on them.
- Supported size is ≤ 6 (64 B, 16 beats). Size > 6 is out of contract and is not checked.
- Only single-beat A messages are supported: Get, and PutFullData with size ≤ 2.
- In every state the non-owner's `d_*` data outputs are driven 0.
- Requesters must hold `a_valid` until handshake (TileLink rule). Dropping `a_valid` early is unsupported.
- Reset mid-transaction returns the FSM to IDLE. The external bus must be reset in the same domain.

## Timing
- Reset values:
  - state = IDLE, `owner` = 0, `last_grant` = 1, `beats_left` = 0.
  - `bus_a_valid` = 0, `bus_d_ready` = 0, `busy_o` = 0.
  - All `mX_a_ready` = 0, all `mX_d_valid` = 0, all data outputs = 0.
- Arbitration latency: a request first seen in IDLE at cycle N produces `bus_a_valid` at N+1.
- The A path and D path are combinational pass-through while the grant is held. There is no added latency per beat.
- The last D beat at cycle N puts the FSM in IDLE at N+1, so the next `bus_a_valid` is no earlier than N+2. This is a fixed 1-cycle bubble between transactions.
- A requester asserting `a_valid` while the other requester owns the bus waits; its `a_ready` stays 0.
- With both requesters valid in IDLE, exactly one is granted that cycle.

## Configuration
- Macro: `TL_FETCH_ARB_RR_EN`.
- **Defined:** round-robin. On a tie, the requester ≠ `last_grant` wins.
- **Undefined:** fixed priority, requester 1 (page-table walker) always wins ties. `last_grant` is still kept but is unused.
- A lone requester is always granted in both modes.

## Structure
- Shared package `tl_pkg`:
  - opcode constants `TL_GET` = 4, `TL_PUTFULL` = 0, `TL_ACCESSACK` = 0, `TL_ACCESSACKDATA` = 1;
  - the `arb_state_t` enum (IDLE/REQ/DATA);
  - the `tl_beats_m1(size)` function that produces the `beats_left` load value.
- Sub-module `arb_pick2`: a combinational 2-way picker with inputs `req[1:0]` and `last`, and output `gnt`. The macro selects its policy.

## Test plan
- **Single Get:** m0 issues Get size=5 (32 B). Expect `bus_a_valid` one cycle after the request. 8 D beats are forwarded to m0, `busy_o` falls after beat 8, and m1 sees no `d_valid`.
- **Tie, RR build:** after reset, m0 and m1 both request. Order is m0, m1, m0 (`last_grant` starts at 1). Each grant starts 2 cycles after the previous last D beat.
- **Tie, fixed build:** m0 and m1 both request repeatedly. m1 always wins, and m0 is granted only when m1 is idle.
- **Back-pressure:** hold `bus_a_ready` = 0 for 3 cycles; the owner's `a_ready` stays 0 for that window. Then toggle `m0_d_ready`: the beat count decrements only on handshakes and all 4 beats of size=4 arrive intact.
- **Denied + Put:** m1 PutFullData size=2 gets AccessAck with `denied` = 1. One beat is forwarded with `denied` = 1 and the FSM returns to IDLE.
- **Reset mid-DATA:** deassert `cpu_reset_ni` after beat 2 of 8. All outputs are immediately at their reset values, and the next request is arbitrated normally.

Source files
------------

// File: rtl/tl_pkg.sv
// tl_pkg: TileLink-UH opcodes, arbiter state type and beat-count helper
// shared by the frontend fetch arbiter.
package tl_pkg;

    localparam logic [2:0] TL_GET           = 3'd4;
    localparam logic [2:0] TL_PUTFULL       = 3'd0;
    localparam logic [2:0] TL_ACCESSACK     = 3'd0;
    localparam logic [2:0] TL_ACCESSACKDATA = 3'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // D beats remaining after the first one, for a Get of 2^size bytes
    // on a 32-bit data bus.
    function automatic logic [3:0] tl_beats_m1(input logic [3:0] size);
        logic [4:0] beats;
        beats = 5'd1;
        if (size > 4'd2) beats = 5'd1 << (size - 4'd2);
        return 4'(beats - 5'd1);
    endfunction

endpackage

// File: rtl/tl_fetch_arbiter_if.sv
// tl_fetch_arbiter_if: one TileLink-UH A/D channel pair (no source field).
// master drives A and accepts D; slave is the opposite side.
interface tl_fetch_arbiter_if;

    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        a_valid;
    logic        a_ready;

    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;
    logic        d_valid;
    logic        d_ready;

    modport master (
        output a_opcode, a_param, a_size, a_address,
        output a_mask, a_data, a_corrupt, a_valid,
        input  a_ready,
        input  d_opcode, d_param, d_size, d_denied,
        input  d_data, d_corrupt, d_valid,
        output d_ready
    );

    modport slave (
        input  a_opcode, a_param, a_size, a_address,
        input  a_mask, a_data, a_corrupt, a_valid,
        output a_ready,
        output d_opcode, d_param, d_size, d_denied,
        output d_data, d_corrupt, d_valid,
        input  d_ready
    );

endinterface

// File: rtl/tl_fetch_arbiter_pick2.sv
// arb_pick2: 2-way grant picker. TL_FETCH_ARB_RR_EN selects round-robin
// ties; otherwise requester 1 wins ties.
module arb_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

`ifdef TL_FETCH_ARB_RR_EN
    assign gnt = (&req) ? ~last : req[1];
`else
    logic unused_last;
    assign unused_last = last;
    assign gnt         = req[1];
`endif

endmodule

// File: rtl/tl_fetch_arbiter.sv
// tl_fetch_arbiter: shares one TileLink-UH master port between icache (m0)
// and page-table walker (m1). Define TL_FETCH_ARB_RR_EN for round-robin.
module tl_fetch_arbiter
    import tl_pkg::*;
(
    input  logic               cpu_clock_i,
    input  logic               cpu_reset_ni,
    tl_fetch_arbiter_if.slave  m0,
    tl_fetch_arbiter_if.slave  m1,
    tl_fetch_arbiter_if.master bus,
    output logic               busy_o
);

    arb_state_t state;
    logic       owner;
    logic       last_grant;
    logic       gnt;
    logic [3:0] beats_left;
    logic       a0, a1, d0, d1;
    logic       a_hs, d_hs;

    arb_pick2 u_pick (
        .req  ({m1.a_valid, m0.a_valid}),
        .last (last_grant),
        .gnt  (gnt)
    );

    assign a0 = (state == REQ)  && !owner;
    assign a1 = (state == REQ)  &&  owner;
    assign d0 = (state == DATA) && !owner;
    assign d1 = (state == DATA) &&  owner;

    assign bus.a_opcode  = a1 ? m1.a_opcode  : a0 ? m0.a_opcode  : '0;
    assign bus.a_param   = a1 ? m1.a_param   : a0 ? m0.a_param   : '0;
    assign bus.a_size    = a1 ? m1.a_size    : a0 ? m0.a_size    : '0;
    assign bus.a_address = a1 ? m1.a_address : a0 ? m0.a_address : '0;
    assign bus.a_mask    = a1 ? m1.a_mask    : a0 ? m0.a_mask    : '0;
    assign bus.a_data    = a1 ? m1.a_data    : a0 ? m0.a_data    : '0;
    assign bus.a_corrupt = a1 ? m1.a_corrupt : a0 && m0.a_corrupt;
    assign bus.a_valid   = (a0 && m0.a_valid) || (a1 && m1.a_valid);
    assign m0.a_ready    = a0 && bus.a_ready;
    assign m1.a_ready    = a1 && bus.a_ready;

    // D beats are steered only by the recorded owner.
    assign m0.d_opcode  = d0 ? bus.d_opcode : '0;
    assign m0.d_param   = d0 ? bus.d_param  : '0;
    assign m0.d_size    = d0 ? bus.d_size   : '0;
    assign m0.d_denied  = d0 && bus.d_denied;
    assign m0.d_data    = d0 ? bus.d_data   : '0;
    assign m0.d_corrupt = d0 && bus.d_corrupt;
    assign m0.d_valid   = d0 && bus.d_valid;

    assign m1.d_opcode  = d1 ? bus.d_opcode : '0;
    assign m1.d_param   = d1 ? bus.d_param  : '0;
    assign m1.d_size    = d1 ? bus.d_size   : '0;
    assign m1.d_denied  = d1 && bus.d_denied;
    assign m1.d_data    = d1 ? bus.d_data   : '0;
    assign m1.d_corrupt = d1 && bus.d_corrupt;
    assign m1.d_valid   = d1 && bus.d_valid;

    assign bus.d_ready = (d0 && m0.d_ready) || (d1 && m1.d_ready);

    assign a_hs   = bus.a_valid && bus.a_ready;
    assign d_hs   = bus.d_valid && bus.d_ready;
    assign busy_o = (state != IDLE);

    always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
        if (!cpu_reset_ni) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            beats_left <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0.a_valid || m1.a_valid) begin
                        owner      <= gnt;
                        last_grant <= gnt;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (a_hs) begin
                        beats_left <= (bus.a_opcode == TL_GET)
                                    ? tl_beats_m1(bus.a_size) : 4'd0;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (d_hs) begin
                        if (beats_left == 4'd0) state <= IDLE;
                        else beats_left <= beats_left - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_fetch_arbiter.sv
// tb_tl_fetch_arbiter: directed and randomized checks of the fetch arbiter
// against a transaction-level reference model.
module tb_tl_fetch_arbiter;
    import tl_pkg::*;

`ifdef TL_FETCH_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
    } a_t;

    typedef struct packed {
        logic        id;
        logic [2:0]  op;
        logic [1:0]  param;
        logic [3:0]  size;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } d_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;
    always #5 clk = ~clk;

    tl_fetch_arbiter_if m0_if ();
    tl_fetch_arbiter_if m1_if ();
    tl_fetch_arbiter_if bus_if ();

    tl_fetch_arbiter dut (
        .cpu_clock_i  (clk),
        .cpu_reset_ni (rst_n),
        .m0           (m0_if),
        .m1           (m1_if),
        .bus          (bus_if),
        .busy_o       (busy)
    );

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   expect_rise = -1;
    a_t   rq[2][$];
    d_t   dq[$];
    int   grants[$];
    int   recv[2];
    logic last_den[2];
    logic dr[2];
    logic txn_open, a_done, own, last_g;
    logic [1:0] pend, pend_prev;
    int   ar_mode, dv_mode, dr_mode, den_mode; // 0 random, 1 high, 2 low

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic pick(input int m);
        if (m == 1) return 1'b1;
        if (m == 2) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    // A Get returns 2^size bytes, 4 per beat; everything else is one beat.
    function automatic int n_beats(input a_t r);
        int bytes;
        bytes = 1 << r.size;
        return (r.op == TL_GET && bytes > 4) ? bytes / 4 : 1;
    endfunction

    function automatic a_t mk(input int p, input logic [2:0] op, input int sz);
        a_t r;
        r.op      = op;
        r.param   = 3'd0;
        r.size    = 4'(sz);
        r.addr    = {p[0], 31'($urandom)};
        r.mask    = 4'($urandom_range(0, 15));
        r.data    = $urandom;
        r.corrupt = 1'b0;
        return r;
    endfunction

    function automatic logic [42:0] d0();
        return {m0_if.d_opcode, m0_if.d_param, m0_if.d_size,
                m0_if.d_denied, m0_if.d_data, m0_if.d_corrupt};
    endfunction

    function automatic logic [42:0] d1();
        return {m1_if.d_opcode, m1_if.d_param, m1_if.d_size,
                m1_if.d_denied, m1_if.d_data, m1_if.d_corrupt};
    endfunction

    task automatic drive();
        a_t a0, a1;
        d_t h;
        a0 = (rq[0].size() != 0) ? rq[0][0] : '0;
        a1 = (rq[1].size() != 0) ? rq[1][0] : '0;
        m0_if.a_valid   = (rq[0].size() != 0);
        m0_if.a_opcode  = a0.op;
        m0_if.a_param   = a0.param;
        m0_if.a_size    = a0.size;
        m0_if.a_address = a0.addr;
        m0_if.a_mask    = a0.mask;
        m0_if.a_data    = a0.data;
        m0_if.a_corrupt = a0.corrupt;
        m1_if.a_valid   = (rq[1].size() != 0);
        m1_if.a_opcode  = a1.op;
        m1_if.a_param   = a1.param;
        m1_if.a_size    = a1.size;
        m1_if.a_address = a1.addr;
        m1_if.a_mask    = a1.mask;
        m1_if.a_data    = a1.data;
        m1_if.a_corrupt = a1.corrupt;
        pend = {m1_if.a_valid, m0_if.a_valid};
        dr[0] = pick(dr_mode);
        dr[1] = pick(dr_mode);
        m0_if.d_ready  = dr[0];
        m1_if.d_ready  = dr[1];
        bus_if.a_ready = pick(ar_mode);
        if (dq.size() != 0) begin
            h = dq[0];
            bus_if.d_valid = pick(dv_mode);
        end else begin
            h        = '0;
            h.op     = 3'($urandom_range(0, 7));
            h.data   = $urandom;
            h.denied = 1'($urandom_range(0, 1));
            bus_if.d_valid = (dv_mode == 0) ? pick(0) : 1'b0;
        end
        bus_if.d_opcode  = h.op;
        bus_if.d_param   = h.param;
        bus_if.d_size    = h.size;
        bus_if.d_denied  = h.denied;
        bus_if.d_data    = h.data;
        bus_if.d_corrupt = h.corrupt;
    endtask

    task automatic monitor();
        a_t   r;
        d_t   h;
        logic w, exp_w, d_act;
        cyc++;
        d_act = (dq.size() != 0);
        if (cyc == expect_rise) chk("a_latency", bus_if.a_valid, 1'b1);
        if (!txn_open && bus_if.a_valid) begin
            chk("a_rise_time", cyc, expect_rise);
            w = bus_if.a_address[31];
            if (pend_prev == 2'b11) exp_w = RR ? ~last_g : 1'b1;
            else exp_w = pend_prev[1];
            chk("winner", w, exp_w);
            txn_open = 1'b1;
            a_done = 1'b0;
            own = w;
            last_g = w;
            grants.push_back(int'(w));
            expect_rise = -1;
        end else if (!txn_open) begin
            expect_rise = (pend != 2'b00) ? cyc + 1 : -1;
        end
        chk("busy", busy, txn_open);
        if (txn_open && !a_done) begin
            r = rq[own][0];
            chk("a_fields", {bus_if.a_opcode, bus_if.a_param, bus_if.a_size,
                bus_if.a_address, bus_if.a_mask, bus_if.a_data,
                bus_if.a_corrupt}, r);
            chk("a_valid", bus_if.a_valid, 1'b1);
            chk("a_ready_own", own ? m1_if.a_ready : m0_if.a_ready,
                bus_if.a_ready);
            chk("a_ready_other", own ? m0_if.a_ready : m1_if.a_ready, 1'b0);
            if (bus_if.a_ready) begin
                void'(rq[own].pop_front());
                a_done = 1'b1;
                for (int i = 0; i < n_beats(r); i++) begin
                    h         = '0;
                    h.id      = own;
                    h.op      = (r.op == TL_GET) ? TL_ACCESSACKDATA : TL_ACCESSACK;
                    h.param   = 2'($urandom_range(0, 3));
                    h.size    = r.size;
                    h.denied  = (den_mode == 0) ? pick(0) : (den_mode == 1);
                    h.data    = $urandom;
                    h.corrupt = 1'($urandom_range(0, 1));
                    dq.push_back(h);
                end
            end
        end else begin
            chk("a_quiet", {bus_if.a_valid, m0_if.a_ready, m1_if.a_ready}, 3'b000);
        end
        if (d_act) begin
            h = dq[0];
            chk("d_fields", h.id ? d1() : d0(),
                {h.op, h.param, h.size, h.denied, h.data, h.corrupt});
            chk("d_valid", h.id ? m1_if.d_valid : m0_if.d_valid, bus_if.d_valid);
            chk("d_other", h.id ? {m0_if.d_valid, d0()} : {m1_if.d_valid, d1()}, '0);
            chk("d_ready", bus_if.d_ready, dr[h.id]);
            if (bus_if.d_valid && dr[h.id]) begin
                void'(dq.pop_front());
                recv[h.id]++;
                last_den[h.id] = h.denied;
                if (dq.size() == 0) txn_open = 1'b0;
            end
        end else begin
            chk("d_quiet", {bus_if.d_ready, m0_if.d_valid, m1_if.d_valid}, 3'b000);
            chk("d_zero", {d0(), d1()}, '0);
        end
        pend_prev = pend;
    endtask

    task automatic tick();
        drive();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int budget);
        for (int i = 0; i < budget &&
             (rq[0].size() + rq[1].size() != 0 || txn_open); i++) tick();
        chk("drain", rq[0].size() + rq[1].size() + int'(txn_open), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rq[0].delete();
        rq[1].delete();
        dq.delete();
        grants.delete();
        txn_open = 1'b0;
        a_done = 1'b0;
        last_g = 1'b1;
        expect_rise = -1;
        pend_prev = 2'b00;
        recv = '{0, 0};
        drive();
        #1;
        chk("rst_ctrl", {bus_if.a_valid, bus_if.d_ready, busy, m0_if.a_ready,
            m1_if.a_ready, m0_if.d_valid, m1_if.d_valid}, 7'd0);
        chk("rst_bus_a", {bus_if.a_opcode, bus_if.a_param, bus_if.a_size,
            bus_if.a_address, bus_if.a_mask, bus_if.a_data,
            bus_if.a_corrupt}, '0);
        chk("rst_d", {d0(), d1()}, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_seq[4];
        int exp_beats;
        int p;
        ar_mode = 1; dv_mode = 1; dr_mode = 1; den_mode = 2;
        do_reset();

        // single Get of 32 bytes on m0
        rq[0].push_back(mk(0, TL_GET, 5));
        run(100);
        chk("get_beats_m0", recv[0], 8);
        chk("get_beats_m1", recv[1], 0);
        chk("get_grants", grants.size(), 1);

        // both requesters contending from reset
        do_reset();
        ar_mode = 0; dv_mode = 0; dr_mode = 0;
        rq[0].push_back(mk(0, TL_GET, $urandom_range(0, 6)));
        rq[0].push_back(mk(0, TL_GET, $urandom_range(0, 6)));
        rq[1].push_back(mk(1, TL_GET, $urandom_range(0, 6)));
        rq[1].push_back(mk(1, TL_PUTFULL, $urandom_range(0, 2)));
        run(1000);
        exp_seq = RR ? '{0, 1, 0, 1} : '{1, 1, 0, 0};
        chk("tie_count", grants.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("tie_order", (i < grants.size()) ? grants[i] : -1, exp_seq[i]);

        // A back-pressure then D back-pressure
        recv = '{0, 0};
        ar_mode = 2; dv_mode = 1; dr_mode = 1;
        rq[0].push_back(mk(0, TL_GET, 4));
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_a_ready", m0_if.a_ready, 1'b0);
            chk("bp_a_valid", bus_if.a_valid, 1'b1);
        end
        ar_mode = 1; dr_mode = 0;
        run(200);
        chk("bp_beats", recv[0], 4);

        // denied PutFullData from m1
        recv = '{0, 0};
        dr_mode = 1; den_mode = 1;
        rq[1].push_back(mk(1, TL_PUTFULL, 2));
        run(100);
        chk("put_beats", recv[1], 1);
        chk("put_denied", last_den[1], 1'b1);
        tick();
        chk("put_idle", busy, 1'b0);
        den_mode = 2;

        // reset in the middle of a burst
        rq[0].push_back(mk(0, TL_GET, 5));
        for (int i = 0; i < 100 && recv[0] < 2; i++) tick();
        chk("mid_beats", recv[0], 2);
        do_reset();
        rq[1].push_back(mk(1, TL_GET, 3));
        run(100);
        chk("post_rst_beats", recv[1], 2);
        chk("post_rst_grant", (grants.size() == 1) ? grants[0] : -1, 1);

        // randomized traffic
        recv = '{0, 0};
        ar_mode = 0; dv_mode = 0; dr_mode = 0; den_mode = 0;
        exp_beats = 0;
        for (int i = 0; i < 40; i++) begin
            p = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0)
                rq[p].push_back(mk(p, TL_PUTFULL, $urandom_range(0, 2)));
            else
                rq[p].push_back(mk(p, TL_GET, $urandom_range(0, 6)));
            exp_beats += n_beats(rq[p][rq[p].size() - 1]);
        end
        run(20000);
        chk("rand_beats", recv[0] + recv[1], exp_beats);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
